// File: rtl/time_sync_ctrl.sv
// Network time-sync controller: button-started fetch with per-attempt timeout and bounded retry.
// Optional `AUTO_RESYNC_EN: also start a sync after RESYNC_CYC idle cycles.
module time_sync_ctrl #(
  parameter int unsigned TS_W        = 32,
  parameter int unsigned OUT_W       = 64,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RESYNC_CYC  = 500_000_000,
  localparam int unsigned RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync_btn,
  output logic             fetch_start,
  input  logic             fetch_done,
  input  logic [TS_W-1:0]  fetch_ts,
  output logic             sync_valid,
  output logic [OUT_W-1:0] sync_time,
  output logic             sync_fail,
  output logic             busy,
  output logic [RW-1:0]    attempt
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  if (OUT_W < TS_W) begin : gen_chk_width
    $error("OUT_W must be >= TS_W");
  end
  if (TIMEOUT_CYC < 1 || RESYNC_CYC < 1) begin : gen_chk_cycles
    $error("TIMEOUT_CYC and RESYNC_CYC must be >= 1");
  end

  typedef enum logic [2:0] {StIdle, StReq, StWait, StApply, StFail} state_e;

  state_e           state_q, state_d;
  logic             btn_prev_q;
  logic             btn_edge;
  logic             start_req;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    attempt_q, attempt_d;
  logic [OUT_W-1:0] sync_time_q, sync_time_d;

  assign btn_edge = sync_btn & ~btn_prev_q;

`ifdef AUTO_RESYNC_EN
  localparam int unsigned CW = (RESYNC_CYC > 1) ? $clog2(RESYNC_CYC) : 1;

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          auto_start;

  assign auto_start = (state_q == StIdle) && (idle_cnt_q == CW'(RESYNC_CYC - 1));
  assign start_req  = btn_edge | auto_start;

  // Any exit from IDLE ends in APPLY, FAIL or cancel, all of which restart the count.
  always_comb begin
    idle_cnt_d = '0;
    if (state_q == StIdle && !start_req) begin
      idle_cnt_d = idle_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign start_req = btn_edge;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    attempt_d   = attempt_q;
    sync_time_d = sync_time_q;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d   = StReq;
          attempt_d = '0;
        end
      end
      StReq: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + TW'(1);
        // Completion wins over both cancel and timeout in the same cycle.
        if (fetch_done) begin
          sync_time_d = OUT_W'(fetch_ts);
          state_d     = StApply;
        end else if (btn_edge) begin
          state_d = StIdle;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          if (attempt_q < RW'(MAX_RETRY)) begin
            attempt_d = attempt_q + RW'(1);
            state_d   = StReq;
          end else begin
            state_d = StFail;
          end
        end
      end
      StApply: state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      btn_prev_q  <= 1'b1;  // a button held through reset must not start a sync
      timer_q     <= '0;
      attempt_q   <= '0;
      sync_time_q <= '0;
    end else begin
      state_q     <= state_d;
      btn_prev_q  <= sync_btn;
      timer_q     <= timer_d;
      attempt_q   <= attempt_d;
      sync_time_q <= sync_time_d;
    end
  end

  assign fetch_start = (state_q == StReq);
  assign sync_valid  = (state_q == StApply);
  assign sync_fail   = (state_q == StFail);
  assign busy        = (state_q != StIdle);
  assign sync_time   = sync_time_q;
  assign attempt     = attempt_q;

endmodule

// File: doc/time_sync_ctrl.md
Name: time_sync_ctrl

Overview:
Parametrised controller for network time synchronisation. It sits between the keypad key-state outputs, the UART internet-time fetcher and the clock interface. A button press starts a request. The block times out stalled fetches and retries a bounded number of times, then either delivers the fetched timestamp as a one-cycle load strobe or reports failure.

Parameters:
TS_W, 32, width of the timestamp returned by the fetcher
OUT_W, 64, width of sync_time; must be >= TS_W; fetch_ts is zero-extended into it
TIMEOUT_CYC, 50_000_000, clk cycles allowed per attempt before it is declared timed out
MAX_RETRY, 3, additional attempts after the first (total attempts = MAX_RETRY+1)
RESYNC_CYC, 500_000_000, idle cycles between automatic syncs (used only with AUTO_RESYNC_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
sync_btn  in  1  level from key state (1 = pressed)
fetch_start  out  1  one-cycle request pulse to fetcher
fetch_done  in  1  fetcher completion pulse; fetch_ts valid in same cycle
fetch_ts  in  TS_W  fetched timestamp
sync_valid  out  1  one-cycle strobe: load sync_time into clock
sync_time  out  OUT_W  last successfully fetched time, zero-extended
sync_fail  out  1  one-cycle pulse: all attempts timed out
busy  out  1  high in every state except IDLE
attempt  out  RW  current attempt index, 0-based; RW = $clog2(MAX_RETRY+1), minimum 1

Behaviour:
- Decided: one clock, clk; reset_n is synchronous, active-low. All state is updated on posedge clk.
- Reset (reset_n=0 at posedge):
  - state=IDLE, all pulse outputs 0, busy 0
  - sync_time 0, attempt 0, timer 0
  - btn_prev=1: a button held through reset does not trigger.
- Edge detect: btn_edge = sync_btn & ~btn_prev; btn_prev <= sync_btn every cycle. Only rising edges act; a held button never re-triggers.
- States are IDLE, REQ, WAIT, APPLY and FAIL. Outputs are Moore, decoded from the registered state.
- IDLE:
  - On btn_edge, go to REQ and set attempt <= 0.
  - fetch_done in IDLE is ignored.
- REQ (1 cycle):
  - fetch_start=1, timer <= 0, then go to WAIT.
  - Latency: edge sampled at cycle N gives fetch_start at N+1 and WAIT at N+2.
- WAIT: timer increments each cycle. Events are checked in priority order:
  1. fetch_done=1: register sync_time <= {0, fetch_ts} and go to APPLY.
  2. btn_edge: user cancel; go to IDLE with no pulse.
  3. timer == TIMEOUT_CYC-1:
     - if attempt < MAX_RETRY: attempt <= attempt+1, go to REQ.
     - otherwise go to FAIL.
- Simultaneous events:
  - fetch_done in the timeout cycle is success.
  - fetch_done together with btn_edge is success.
- APPLY (1 cycle): sync_valid=1 and sync_time already holds the new value; then go to IDLE. sync_valid rises in the cycle after fetch_done.
- FAIL (1 cycle): sync_fail=1, sync_time unchanged, then go to IDLE.
- attempt holds its last value in IDLE until the next start.
- timer width is $clog2(TIMEOUT_CYC) bits; it never wraps because it is cleared in REQ.
- Reset asserted in any state returns to IDLE on the next posedge. No pulse is emitted, and a fetch_done arriving afterwards is ignored.
- sync_time changes only in the WAIT-to-APPLY transition or on reset.

Optional Feature:
AUTO_RESYNC_EN
- Defined:
  - An idle counter increments only in IDLE.
  - It clears on reset and in every APPLY or FAIL cycle.
  - When it reaches RESYNC_CYC-1 in IDLE, the block goes to REQ exactly as on btn_edge, and the counter clears.
  - btn_edge in the same cycle is treated as a single start.
  - A manual cancel in WAIT also clears the counter.
- Undefined: no counter logic exists, RESYNC_CYC is unused, and only btn_edge starts a sync.

Test Plan:
(Bench parameters: TIMEOUT_CYC=100, MAX_RETRY=2, TS_W=32, OUT_W=64.)
- Reset with sync_btn held 1, then release reset -> no fetch_start; all outputs 0, sync_time=0.
- Press sync_btn (0->1) at cycle N; fetch_done with fetch_ts=0x66E1_A2B0 four cycles after WAIT entry -> fetch_start at N+1; sync_valid exactly one cycle later than fetch_done; sync_time=0x0000_0000_66E1_A2B0; busy low after APPLY.
- Press with no fetch_done -> three fetch_start pulses spaced 101 cycles apart; attempt shows 0, 1, 2; one sync_fail pulse; sync_time unchanged.
- Press, first attempt times out, fetch_done during the second attempt exactly at timer=99 -> sync_valid, no sync_fail, attempt=1.
- Press, then second rising edge at cycle 20 of WAIT -> IDLE, no sync_valid or sync_fail; a later fetch_done is ignored.
- AUTO_RESYNC_EN with RESYNC_CYC=50 -> fetch_start 50 cycles after reset with no button; after success, next auto start 50 idle cycles after APPLY.
